// File: rtl/pipe_skid_reg.sv
// Purpose     : pipeline-stage register with a two-entry skid buffer carrying instr/PC/sideband.
// Latency     : 1 cycle; a beat accepted at edge N is on Out_* with Out_Valid=1 right after edge N.
// Backpressure: In_Ready = !skid valid (registered only); the skid entry absorbs the beat already committed upstream.
//
// Ports:
//   Clk, Reset          clock (rising edge) and asynchronous active-high reset
//   In_Valid/In_Ready   upstream handshake; In_Instr/In_PC/In_Sb upstream payload
//   Out_Valid/Out_Ready downstream handshake; Out_Instr/Out_PC/Out_Sb output payload (main entry)
//   Flush, Flush_PC     drop all contents and load a bubble {RESET_INSTR, Flush_PC, 0}
//   Occupancy           number of held entries (0, 1 or 2)
module pipe_skid_reg #(
    parameter int unsigned        INSTR_W     = 32,
    parameter int unsigned        PC_W        = 32,
    parameter int unsigned        SB_W        = 8,
    parameter logic [INSTR_W-1:0] RESET_INSTR = '0,
    parameter logic [PC_W-1:0]    RESET_PC    = 32'h0000_3000
) (
    input  logic               Clk,
    input  logic               Reset,

    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [INSTR_W-1:0] In_Instr,
    input  logic [PC_W-1:0]    In_PC,
    input  logic [SB_W-1:0]    In_Sb,

    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [INSTR_W-1:0] Out_Instr,
    output logic [PC_W-1:0]    Out_PC,
    output logic [SB_W-1:0]    Out_Sb,

    input  logic               Flush,
    input  logic [PC_W-1:0]    Flush_PC,

    output logic [1:0]         Occupancy
);

    // ------------------------------------------------------------------
    // Payload and state types
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [SB_W-1:0]    sb;
    } beat_t;

    // EMPTY: nothing held. ONE: main valid. FULL: main and skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e state_q;
    state_e state_d;

    beat_t  main_q;
    beat_t  main_d;
    beat_t  skid_q;
    beat_t  skid_d;

    beat_t  in_beat;
    beat_t  bubble_beat;
    beat_t  reset_beat;

    logic   main_vld;
    logic   skid_vld;
    logic   accept;
    logic   drain;

    // ------------------------------------------------------------------
    // Handshakes. Both are built from registered state and the peer's
    // inputs only, so no combinational path runs Out_Ready -> In_Ready.
    // ------------------------------------------------------------------
    assign in_beat     = '{instr: In_Instr,    pc: In_PC,    sb: In_Sb};
    assign bubble_beat = '{instr: RESET_INSTR, pc: Flush_PC, sb: '0};
    assign reset_beat  = '{instr: RESET_INSTR, pc: RESET_PC, sb: '0};

    assign main_vld = (state_q != ST_EMPTY);
    assign skid_vld = (state_q == ST_FULL);

    assign accept = In_Valid  & ~skid_vld;
    assign drain  = Out_Ready & main_vld;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Flush overrides every other event; a drain in
    // the same cycle still completes because downstream already sampled it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        state_d = ST_FULL;
                    end else if (!accept && drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // accept is impossible here: In_Ready is low while FULL
                    if (drain) begin
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs that depend on state only
    // ------------------------------------------------------------------
    always_comb begin
        Out_Valid = 1'b0;
        In_Ready  = 1'b1;
        Occupancy = 2'd0;
        unique case (state_q)
            ST_EMPTY: begin
                Out_Valid = 1'b0;
                In_Ready  = 1'b1;
                Occupancy = 2'd0;
            end
            ST_ONE: begin
                Out_Valid = 1'b1;
                In_Ready  = 1'b1;
                Occupancy = 2'd1;
            end
            ST_FULL: begin
                Out_Valid = 1'b1;
                In_Ready  = 1'b0;
                Occupancy = 2'd2;
            end
            default: begin
                Out_Valid = 1'b0;
                In_Ready  = 1'b1;
                Occupancy = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state. The main entry keeps its payload when it drains
    // to EMPTY, so Out_* shows the last loaded beat until something new lands.
    // ------------------------------------------------------------------
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (Flush) begin
            // Skid payload is left as-is; its valid bit is cleared via state.
            main_d = bubble_beat;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d = in_beat;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_d = in_beat;
                    end else if (accept) begin
                        skid_d = in_beat;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_d = skid_q;
                    end
                end
                default: begin
                    main_d = main_q;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            main_q <= reset_beat;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign Out_Instr = main_q.instr;
    assign Out_PC    = main_q.pc;
    assign Out_Sb    = main_q.sb;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference.
module tb_pipe_skid_reg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  sb;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [7:0]  in_sb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [7:0]  out_sb;
    logic        flush;
    logic [31:0] flush_pc;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;
    int dut_drains = 0;
    int m_drains   = 0;
    bit cmp_en = 0;

    pipe_skid_reg dut (
        .Clk       (clk),
        .Reset     (rst),
        .In_Valid  (in_valid),
        .In_Ready  (in_ready),
        .In_Instr  (in_instr),
        .In_PC     (in_pc),
        .In_Sb     (in_sb),
        .Out_Valid (out_valid),
        .Out_Ready (out_ready),
        .Out_Instr (out_instr),
        .Out_PC    (out_pc),
        .Out_Sb    (out_sb),
        .Flush     (flush),
        .Flush_PC  (flush_pc),
        .Occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference: an ordered list of held beats (at most two) plus the
    // payload currently shown on the output when nothing is held.
    // ------------------------------------------------------------------
    beat_t q[$];
    beat_t shown;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            shown = '{instr: 32'h0, pc: 32'h0000_3000, sb: 8'h0};
        end else begin
            bit acc;
            bit drn;
            beat_t gone;
            acc = in_valid && (q.size() < 2);
            drn = out_ready && (q.size() > 0);
            if (drn) begin
                gone = q.pop_front();
                m_drains++;
            end
            if (flush) begin
                q.delete();
                shown = '{instr: 32'h0, pc: flush_pc, sb: 8'h0};
            end else begin
                if (acc) q.push_back('{instr: in_instr, pc: in_pc, sb: in_sb});
                if (q.size() > 0) shown = q[0];
            end
        end
    end

    // Beats actually handed downstream by the DUT (pre-edge values).
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) dut_drains++;
    end

    // Per-cycle comparison against the reference.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_out_valid", out_valid, q.size() > 0);
            chk("m_in_ready",  in_ready,  q.size() < 2);
            chk("m_occupancy", occupancy, q.size());
            chk("m_out_instr", out_instr, shown.instr);
            chk("m_out_pc",    out_pc,    shown.pc);
            chk("m_out_sb",    out_sb,    shown.sb);
        end
    end

    // Drive one cycle of inputs, starting just after a falling edge.
    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [7:0] sb, input logic ordy, input logic fl,
                         input logic [31:0] fpc);
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        in_sb     = sb;
        out_ready = ordy;
        flush     = fl;
        flush_pc  = fpc;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'h0, 32'h0, 8'h0, ordy, 1'b0, 32'h0);
    endtask

    int d0;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; in_sb = '0;
        out_ready = 1'b0; flush = 1'b0; flush_pc = '0;
        repeat (3) @(negedge clk);

        // Reset release
        rst = 1'b0;
        #1;
        chk("rst_out_pc",    out_pc,    32'h3000);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_occupancy", occupancy, 2'd0);
        cmp_en = 1'b1;
        @(negedge clk);

        // Streaming: 8 beats, Out_Ready held high
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h1000_0000 + i, 32'h3000 + 4 * i, 8'(i), 1'b1, 1'b0, 32'h0);
            chk("stream_pc",    out_pc,    32'h3000 + 4 * i);
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_occ",   occupancy, 2'd1);
        end
        idle(1'b1);
        chk("stream_end_occ", occupancy, 2'd0);

        // Back-pressure: three stalled cycles, then release
        drive(1'b1, 32'h2000_0000, 32'h3000, 8'h10, 1'b0, 1'b0, 32'h0);
        chk("bp_occ1", occupancy, 2'd1);
        chk("bp_rdy1", in_ready, 1'b1);
        drive(1'b1, 32'h2000_0001, 32'h3004, 8'h11, 1'b0, 1'b0, 32'h0);
        chk("bp_occ2", occupancy, 2'd2);
        chk("bp_rdy2", in_ready, 1'b0);
        chk("bp_hold_pc", out_pc, 32'h3000);
        drive(1'b1, 32'h2000_0002, 32'h3008, 8'h12, 1'b0, 1'b0, 32'h0);
        chk("bp_occ3", occupancy, 2'd2);
        chk("bp_rdy3", in_ready, 1'b0);
        drive(1'b1, 32'h2000_0002, 32'h3008, 8'h12, 1'b1, 1'b0, 32'h0);
        chk("bp_rel_pc1", out_pc, 32'h3004);
        chk("bp_rel_occ1", occupancy, 2'd1);
        drive(1'b1, 32'h2000_0002, 32'h3008, 8'h12, 1'b1, 1'b0, 32'h0);
        chk("bp_rel_pc2", out_pc, 32'h3008);
        chk("bp_rel_sb2", out_sb, 8'h12);
        idle(1'b1);
        chk("bp_end_occ", occupancy, 2'd0);

        // Flush while FULL
        drive(1'b1, 32'h3000_0000, 32'h3100, 8'h20, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h3000_0001, 32'h3104, 8'h21, 1'b0, 1'b0, 32'h0);
        chk("fl_full_occ", occupancy, 2'd2);
        drive(1'b0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b1, 32'h4180);
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_pc",    out_pc,    32'h4180);
        chk("fl_instr", out_instr, 32'h0);
        chk("fl_occ",   occupancy, 2'd0);
        chk("fl_rdy",   in_ready,  1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk("fl_no_skid_valid", out_valid, 1'b0);
            chk("fl_no_skid_pc",    out_pc,    32'h4180);
        end

        // Flush with simultaneous accept and drain while ONE
        drive(1'b1, 32'h4000_0000, 32'h3200, 8'h30, 1'b0, 1'b0, 32'h0);
        chk("fa_one_occ", occupancy, 2'd1);
        d0 = dut_drains;
        drive(1'b1, 32'h4000_0001, 32'h3204, 8'h31, 1'b1, 1'b1, 32'h5000);
        chk("fa_drain_once", dut_drains, d0 + 1);
        chk("fa_occ",   occupancy, 2'd0);
        chk("fa_valid", out_valid, 1'b0);
        chk("fa_pc",    out_pc,    32'h5000);
        idle(1'b1);
        idle(1'b1);
        chk("fa_dropped", dut_drains, d0 + 1);

        // Asynchronous reset pulse between edges while FULL
        drive(1'b1, 32'h5000_0000, 32'h3300, 8'h40, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h5000_0001, 32'h3304, 8'h41, 1'b0, 1'b0, 32'h0);
        chk("ar_full_occ", occupancy, 2'd2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_pc",    out_pc,    32'h3000);
        chk("ar_instr", out_instr, 32'h0);
        chk("ar_sb",    out_sb,    8'h0);
        chk("ar_occ",   occupancy, 2'd0);
        chk("ar_rdy",   in_ready,  1'b1);
        #1 rst = 1'b0;
        @(negedge clk);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, 8'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("drain_total", dut_drains, m_drains);
        chk("final_occ", occupancy, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
